nes_line_doubler: RTL
=====================

Name: nes_line_doubler

Overview:
- Ping-pong line buffer between the PPU pixel stream and the VGA output stage, all on the 12.5 MHz pixel clock.
- Accepts 256-pixel NES lines through a valid/ready handshake and stores them in two 256x8 banks.
- Replays each stored line on two consecutive VGA lines (240 -> 480), driving the 8-bit framebuffer read-data input of the VGA output stage with correct horizontal alignment.
- Lets the PPU run ahead by at most one line and reports underrun and frame-misalignment errors.

Parameters:
- DATA_W, 8, pixel width (palette index) on the write and read sides
- LINE_W, 256, NES pixels per line and entries per bank
- H_START, 32, first VGA column (pixel_x) showing NES pixel 0
- H_TOTAL, 400, VGA columns per line (pixel_x 0..399)
- V_ACTIVE, 480, active VGA lines (pixel_y 0..479)

Ports:
- pix_clk  in  1  12.5 MHz pixel clock; only clock
- rst  in  1  synchronous reset, active-high
- ppu_pix  in  DATA_W  incoming pixel, NES pixel order left to right
- ppu_valid  in  1  ppu_pix valid
- ppu_sof  in  1  qualifies the current beat as pixel 0 of NES line 0
- ppu_ready  out  1  buffer can accept a beat
- rd_x  in  10  VGA column counter, 0..399, advances by 1 per clock
- rd_y  in  10  VGA line counter, 0..524
- DO  out  DATA_W  pixel data to the VGA output stage's DI input
- underrun  out  1  sticky: a line was due but not ready
- frame_err  out  1  sticky: ppu_sof arrived mid-line

Behaviour:
- Reset (rst=1 at a pix_clk edge):
  - full[1:0]=0, wbank=0, rbank=0, wptr=0.
  - DO=0, underrun=0, frame_err=0.
  - ppu_ready is 0 while rst=1.
- Write side:
  - A beat is accepted when ppu_valid && ppu_ready.
  - ppu_ready = !full[wbank] && !rst, combinational.
  - On accept: mem[wbank][wptr] <= ppu_pix, then wptr increments.
  - When wptr==LINE_W-1 is accepted: full[wbank]<=1, wbank toggles, wptr<=0.
- ppu_sof on an accepted beat:
  - If wptr!=0, set frame_err and discard the partial line.
  - The beat is written at index 0 of wbank; wptr<=1.
- Read side (1-cycle registered latency):
  - When rd_y<V_ACTIVE and rd_x==H_START-1+k (k=0..LINE_W-1): DO <= mem[rbank][k] if full[rbank], else DO <= 0 and underrun<=1.
  - Result: DO holds pixel k while rd_x==H_START+k.
  - In all other cycles DO<=0, giving black borders and blanking.
- Line release:
  - At rd_x==H_TOTAL-1 with rd_y<V_ACTIVE and rd_y[0]==1 (second replay done), if full[rbank]: full[rbank]<=0 and rbank toggles.
  - If the bank is not full, nothing is released.
  - Even VGA lines never release, so each NES line is shown on lines 2n and 2n+1.
  - No release during vertical blank (rd_y>=480).
- Simultaneous events:
  - Write completion and release in the same cycle always target different banks. Both take effect.
  - If a release frees the bank equal to wbank, ppu_ready rises on the next cycle, not the same one.
- Underrun: a line that is underrun on both replays is skipped; it is not delayed to later VGA lines.
- Reset mid-line: all buffered data is dropped. The read side outputs 0 with underrun held 0 until the first bank fills.
  - underrun is not set by the empty reads that occur before the first line is ever completed after reset, so an empty-start flag is needed.
- The memory has no reset; contents are undefined until written.

Test Plan:
- Reset, then stream 256 pixels with value=index (0..255, no stalls) before rd_y=0. Expect: rd_y=0 and rd_y=1 show DO=k at rd_x=32+k; DO=0 at rd_x 0..31 and 288..399; underrun=0.
- Hold ppu_valid high continuously. Expect: ppu_ready falls after 512 accepted beats, and rises one cycle after the release at rd_y=1, rd_x=399.
- Deliver line 1 (all 8'hA5) late, during VGA line 2. Expect: underrun=1; DO=0 on line 2 active pixels; line 1 shown on line 3.
- Assert ppu_sof at wptr=100. Expect: frame_err=1; the next 255 beats plus the sof beat form one line; the sof beat's pixel appears at rd_x=32.
- Assert rst for one cycle mid-line with both banks full. Expect: full cleared, DO=0, ppu_ready=1 on the following cycle, underrun stays 0 until the first line is completed.
- Run a full 525-line frame with 240 lines of value=(line & 8'hFF). Expect: VGA line y shows y>>1 on all 256 pixels; no releases for y>=480.

Source files
------------

// File: rtl/nes_line_doubler.sv
// nes_line_doubler: ping-pong line buffer between the PPU pixel stream
// and the VGA output stage; each 256-pixel NES line is shown twice.
module nes_line_doubler #(
    parameter int DATA_W   = 8,
    parameter int LINE_W   = 256,
    parameter int H_START  = 32,
    parameter int H_TOTAL  = 400,
    parameter int V_ACTIVE = 480
) (
    input  logic              pix_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ppu_pix,
    input  logic              ppu_valid,
    input  logic              ppu_sof,
    output logic              ppu_ready,
    input  logic [9:0]        rd_x,
    input  logic [9:0]        rd_y,
    output logic [DATA_W-1:0] DO,
    output logic              underrun,
    output logic              frame_err
);

    localparam int AW = $clog2(LINE_W);

    localparam logic [9:0]    L_RD_FIRST = 10'(H_START - 1);
    localparam logic [9:0]    L_RD_LAST  = 10'(H_START - 2 + LINE_W);
    localparam logic [9:0]    L_X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    L_Y_ACT    = 10'(V_ACTIVE);
    localparam logic [AW-1:0] L_PTR_LAST = AW'(LINE_W - 1);

    // two banks of LINE_W entries, addressed {bank, pixel}
    logic [DATA_W-1:0] r_mem [0:2*LINE_W-1];

    logic [1:0]        r_full;
    logic              r_wbank;
    logic              r_rbank;
    logic [AW-1:0]     r_wptr;
    logic [DATA_W-1:0] r_do;
    logic              r_underrun;
    logic              r_frame_err;
    logic              r_primed;

    logic              w_ready;
    logic              w_acc;
    logic [AW-1:0]     w_widx;
    logic              w_wdone;
    logic              w_act_y;
    logic              w_rd_win;
    logic [AW-1:0]     w_rd_k;
    logic              w_release;
    logic [1:0]        w_full_nxt;

    assign w_ready  = !r_full[r_wbank] && !rst;
    assign w_acc    = ppu_valid && w_ready;
    // a start-of-frame beat always lands at pixel 0
    assign w_widx   = ppu_sof ? '0 : r_wptr;
    assign w_wdone  = w_acc && (w_widx == L_PTR_LAST);

    assign w_act_y  = rd_y < L_Y_ACT;
    // fetch one column early so DO lines up with rd_x a cycle later
    assign w_rd_win = w_act_y && (rd_x >= L_RD_FIRST)
                      && (rd_x <= L_RD_LAST);
    assign w_rd_k   = rd_x[AW-1:0] - L_RD_FIRST[AW-1:0];

    // only the odd (second) replay of an active line frees its bank
    assign w_release = w_act_y && (rd_x == L_X_LAST) && rd_y[0]
                       && r_full[r_rbank];

    // full flags: completion and release always hit different banks
    always_comb begin
        w_full_nxt = r_full;
        if (w_wdone) begin
            w_full_nxt[r_wbank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
    end

    // pixel storage, no reset
    always_ff @(posedge pix_clk) begin
        if (w_acc) begin
            r_mem[{r_wbank, w_widx}] <= ppu_pix;
        end
    end

    // write side: pointer, bank select, occupancy, framing error
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_full      <= 2'b00;
            r_wbank     <= 1'b0;
            r_wptr      <= '0;
            r_frame_err <= 1'b0;
            r_primed    <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_acc) begin
                if (ppu_sof && (r_wptr != '0)) begin
                    r_frame_err <= 1'b1;
                end
                if (w_wdone) begin
                    r_wptr   <= '0;
                    r_wbank  <= ~r_wbank;
                    r_primed <= 1'b1;
                end else begin
                    r_wptr <= w_widx + 1'b1;
                end
            end
        end
    end

    // read side: registered pixel fetch, underrun flag, bank swap
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_rbank    <= 1'b0;
            r_do       <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_do <= '0;
            if (w_rd_win) begin
                if (r_full[r_rbank]) begin
                    r_do <= r_mem[{r_rbank, w_rd_k}];
                end else if (r_primed) begin
                    r_underrun <= 1'b1;
                end
            end
            if (w_release) begin
                r_rbank <= ~r_rbank;
            end
        end
    end

    assign ppu_ready = w_ready;
    assign DO        = r_do;
    assign underrun  = r_underrun;
    assign frame_err = r_frame_err;

endmodule
